// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter that shares one DDR burst engine among several memory
// clients. It latches the winner's address and direction, drives one burst,
// and pulses done back to the winner when the burst completes or times out.
module ddr_req_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_wr,
  input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_REQ-1:0]                done,
  output logic                              rd_burst_req,
  output logic                              wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0]         burst_addr,
  output logic [9:0]                        burst_len,
  input  logic                              rd_burst_finish,
  input  logic                              wr_burst_finish,
  output logic                              timeout_err,
  output logic                              busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic                      dir, dir_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [IDX_W-1:0]          last_ptr, last_nxt;
  logic [NUM_REQ-1:0]        grant_nxt, done_nxt;
  logic                      rd_nxt, wr_nxt, terr_nxt, busy_nxt;
  logic [DDR_ADDR_WIDTH-1:0] addr_nxt;

  logic [DDR_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic                      win_found;
  logic [IDX_W-1:0]          win_idx;
  logic [IDX_W-1:0]          scan_idx;
  int                        scan_pos;
  logic                      fin_match;

  assign burst_len = 10'(BURST_LEN);

  // Unpack the flat address bus into one entry per port.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
  end

  // Round-robin pick: first requester after the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      scan_pos = int'(last_ptr) + k;
      if (scan_pos >= int'(NUM_REQ)) scan_pos = scan_pos - int'(NUM_REQ);
      scan_idx = IDX_W'(scan_pos);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    last_nxt  = last_ptr;
    grant_nxt = grant;
    done_nxt  = '0;
    rd_nxt    = rd_burst_req;
    wr_nxt    = wr_burst_req;
    addr_nxt  = burst_addr;
    terr_nxt  = timeout_err;
    busy_nxt  = busy;
    fin_match = dir ? wr_burst_finish : rd_burst_finish;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = BUSY;
          idx_nxt   = win_idx;
          dir_nxt   = req_wr[win_idx];
          addr_nxt  = addr_arr[win_idx];
          cnt_nxt   = '0;
          grant_nxt = NUM_REQ'(1) << win_idx;
          busy_nxt  = 1'b1;
          rd_nxt    = ~req_wr[win_idx];
          wr_nxt    = req_wr[win_idx];
        end
      end
      BUSY: begin
        if (fin_match || cnt == CNT_MAX) begin
          state_nxt = DONE;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          done_nxt  = grant;
          if (!fin_match) terr_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        last_nxt  = idx;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      dir          <= 1'b0;
      cnt          <= '0;
      last_ptr     <= LAST_RST;
      grant        <= '0;
      done         <= '0;
      rd_burst_req <= 1'b0;
      wr_burst_req <= 1'b0;
      burst_addr   <= '0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      dir          <= dir_nxt;
      cnt          <= cnt_nxt;
      last_ptr     <= last_nxt;
      grant        <= grant_nxt;
      done         <= done_nxt;
      rd_burst_req <= rd_nxt;
      wr_burst_req <= wr_nxt;
      burst_addr   <= addr_nxt;
      timeout_err  <= terr_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule
